// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the APB register side and the UART transmitter: active-low push/pop strobes,
// registered head byte, register-decoded flags. Define UART_TX_FIFO_ERR_EN to enable the sticky overflow flag.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  write_n,
   input  logic [WIDTH-1:0]      data_in,
   input  logic                  read_n,
   input  logic                  flush,
   output logic [WIDTH-1:0]      data_out,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  clr_err
);

   localparam int unsigned ENTRIES = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(ENTRIES);
   localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

   logic [WIDTH-1:0]      mem [ENTRIES];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [WIDTH-1:0]      data_out_q, data_out_d;
   logic                  overflow_q, overflow_d;
   logic                  push_ok, pop_ok, drop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign level      = count_q;
   assign data_out   = data_out_q;
   assign overflow   = overflow_q;

   always_comb begin
      pop_ok     = !read_n && !fifo_empty && !flush;
      // A full FIFO still takes a push when the same cycle frees the head slot.
      push_ok    = !write_n && (!fifo_full || pop_ok) && !flush;
      drop       = !write_n && fifo_full && !pop_ok && !flush;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + ONE_PTR;
         if (pop_ok) begin
            rptr_d     = rptr_q + ONE_PTR;
            data_out_d = mem[rptr_q];
         end
         if (push_ok && !pop_ok)      count_d = count_q + ONE_CNT;
         else if (pop_ok && !push_ok) count_d = count_q - ONE_CNT;
      end
`ifdef UART_TX_FIFO_ERR_EN
      overflow_d = overflow_q;
      if (clr_err) overflow_d = 1'b0;
      if (drop)    overflow_d = 1'b1;
`else
      overflow_d = 1'b0;
`endif
   end

`ifndef UART_TX_FIFO_ERR_EN
   logic unused_clr_err;
   assign unused_clr_err = clr_err ^ drop;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         data_out_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage has no reset so it can map onto distributed/block RAM.
   always_ff @(posedge clk) begin
      if (push_ok && reset_n) mem[wptr_q] <= data_in;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pops queue their expected head byte, a monitor compares data_out after each pop strobe.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       write_n = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       read_n = 1'b1;
   logic       flush = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] data_out;
   logic       fifo_empty, fifo_full, overflow;
   logic [4:0] level;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   uart_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .write_n(write_n), .data_in(data_in),
      .read_n(read_n), .flush(flush), .data_out(data_out), .fifo_empty(fifo_empty),
      .fifo_full(fifo_full), .level(level), .overflow(overflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      write_n = 1'b0; data_in = b;
      tick();
      write_n = 1'b1;
   endtask

   task automatic pop(input logic [7:0] exp);
      read_n = 1'b0;
      exp_q.push_back(exp);
      tick();
      read_n = 1'b1;
   endtask

   task automatic push_pop(input logic [7:0] b, input logic [7:0] exp);
      write_n = 1'b0; data_in = b; read_n = 1'b0;
      exp_q.push_back(exp);
      tick();
      write_n = 1'b1; read_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   // Monitor: every pop strobe sampled while out of reset has a queued expected head byte.
   initial begin
      logic rd, rs;
      forever begin
         @(posedge clk);
         rd = read_n;
         rs = reset_n;
         #2;
         if (!rd && rs) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL pop_unexpected: data_out %0h with no expected entry", data_out);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (data_out !== e) begin
                  n_err++;
                  $display("FAIL pop_data: got %0h expected %0h", data_out, e);
               end else begin
                  $display("ok   pop_data: %0h", data_out);
               end
            end
         end
      end
   end

   initial begin
      idle(3);
      reset_n = 1'b1;
      idle(2);
      check("rst_empty", fifo_empty, 1);
      check("rst_full", fifo_full, 0);
      check("rst_level", level, 0);
      check("rst_dout", data_out, 8'h00);
      check("rst_ovf", overflow, 0);

      push(8'h41); push(8'h42); push(8'h43);
      check("lvl3", level, 3);
      check("not_empty", fifo_empty, 0);
      pop(8'h41); check("lvl2", level, 2); idle(3);
      pop(8'h42); check("lvl1", level, 1); idle(3);
      pop(8'h43); check("lvl0", level, 0);
      check("empty_after3", fifo_empty, 1);

      for (int i = 0; i < 16; i++) push(8'(i));
      check("full_flag", fifo_full, 1);
      check("full_level", level, 16);
      push(8'hAA);
      check("drop_level", level, 16);
      check("drop_ovf", overflow, ERR_EN);
      idle(2);
      check("ovf_sticky", overflow, ERR_EN);
      clr_err = 1'b1; tick(); clr_err = 1'b0;
      check("ovf_cleared", overflow, 0);

      push_pop(8'h55, 8'h00);
      check("full_pp_level", level, 16);
      check("full_pp_ovf", overflow, 0);
      for (int i = 1; i < 16; i++) pop(8'(i));
      pop(8'h55);
      check("drain_empty", fifo_empty, 1);

      push(8'h80); push(8'h81);
      for (int i = 0; i < 40; i++) begin
         push_pop(8'(8'h82 + i), 8'(8'h80 + i));
         check("wrap_level", level, 2);
      end
      pop(8'hA8); pop(8'hA9);
      check("wrap_empty", level, 0);

      for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
      check("pre_flush_lvl", level, 5);
      flush = 1'b1; write_n = 1'b0; data_in = 8'h99;
      tick();
      flush = 1'b0; write_n = 1'b1;
      check("flush_level", level, 0);
      check("flush_empty", fifo_empty, 1);
      check("flush_dout", data_out, 8'hA9);
      pop(8'hA9);
      check("empty_pop_lvl", level, 0);
      push(8'h33);
      pop(8'h33);

      push(8'h61); push(8'h62);
      pop(8'h61);
      #2 reset_n = 1'b0;
      #1;
      check("arst_dout", data_out, 8'h00);
      check("arst_level", level, 0);
      check("arst_empty", fifo_empty, 1);
      check("arst_full", fifo_full, 0);
      check("arst_ovf", overflow, 0);
      tick();
      reset_n = 1'b1;
      idle(2);
      check("post_rst_level", level, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Synchronous transmit FIFO for the CoreUARTapb UART. It sits between the APB register interface and the asynchronous transmitter.
- The register side pushes bytes with a one-cycle active-low write strobe.
- The transmitter pops them with its active-low one-cycle `fifo_read_tx` strobe and samples the registered output byte three clocks later.
- Empty and full flags are registered-state decodes that feed the transmitter's `fifo_empty` / `fifo_full` inputs directly.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: log2 of entry count (16 entries); legal range 2..8.
- `WIDTH`, default 8: data width in bits.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: system clock; all state updates on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `write_n`, in, 1: active-low push strobe; one push per clock sampled low.
- `data_in`, in, WIDTH: byte to push; sampled when `write_n`=0.
- `read_n`, in, 1: active-low pop strobe; connected to the transmitter's `fifo_read_tx`.
- `flush`, in, 1: active-high synchronous clear of contents.
- `data_out`, out, WIDTH: registered head byte; connected to the transmitter's `tx_dout_reg`.
- `fifo_empty`, out, 1: high when the entry count is 0.
- `fifo_full`, out, 1: high when the entry count is 2^DEPTH_LOG2.
- `level`, out, DEPTH_LOG2+1: current entry count.
- `overflow`, out, 1: sticky error flag; see Configuration.
- `clr_err`, in, 1: synchronous clear of the sticky flags.

## Operation
- Storage is a 2^DEPTH_LOG2 × WIDTH register array.
- Pointers:
  - Write pointer `wptr` and read pointer `rptr` are each DEPTH_LOG2 bits wide.
  - Both wrap modulo 2^DEPTH_LOG2 with no special case at the top entry.
- `count` register:
  - DEPTH_LOG2+1 bits wide; `level` = `count`.
  - `fifo_empty` = (`count`==0) and `fifo_full` = (`count`==2^DEPTH_LOG2).
  - Both flags are decoded from the register only; there is no combinational path from any input to any output.
- Accepted push (`write_n`=0 and `fifo_full`=0, or `write_n`=0 with `fifo_full`=1 and an accepted pop in the same cycle):
  - mem[`wptr`] <= `data_in`;
  - `wptr` increments.
- Accepted pop (`read_n`=0 and `fifo_empty`=0):
  - `data_out` <= mem[`rptr`];
  - `rptr` increments.
  - `data_out` holds its value until the next accepted pop.
- Count update:
  - push only: `count`+1;
  - pop only: `count`−1;
  - push and pop together: `count` unchanged.
- Push while full, with no pop in the same cycle: dropped; storage and pointers unchanged.
- Pop while empty: ignored; `data_out` unchanged. There is no fall-through of a same-cycle push.
- `flush`=1:
  - `wptr`, `rptr` and `count` go to 0;
  - `data_out` keeps its value;
  - `flush` overrides any push or pop in the same cycle.
- Reset values: `wptr`=0, `rptr`=0, `count`=0, `data_out`=0, `overflow`=0.
  - Resulting outputs: `fifo_empty`=1, `fifo_full`=0, `level`=0.
  - Memory contents are not reset.
- Reset asserted mid-operation: all of the above values apply immediately, asynchronously; any in-flight push or pop is lost.

## Timing
- Push at edge N: `fifo_empty` falls and `level` increments after edge N (visible in cycle N+1).
- Pop at edge N: `data_out` is valid after edge N.
  - The transmitter samples it at least 2 clocks later, after its delay and load states.
- After a pop at edge N, flags and `level` update after edge N. The transmitter cannot re-issue a pop before edge N+3, so no underflow arises from flag lag.
- Back-to-back pushes are supported at one per clock.
- Pops are one per clock maximum.
- Write-to-read latency through the FIFO: minimum 1 clock. Push at edge N; pop possible at edge N+1.

## Configuration
- Macro: `UART_TX_FIFO_ERR_EN`.
- Defined:
  - `overflow` sets on any dropped push (push while full, no pop in the same cycle).
  - `overflow` stays high until `clr_err`=1 or reset.
  - If `clr_err` and a new drop occur in the same cycle, `overflow` ends high (set wins).
- Undefined:
  - `overflow` is tied 0 and `clr_err` is ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then idle:
  - outputs are `fifo_empty`=1, `fifo_full`=0, `level`=0, `data_out`=0x00, `overflow`=0.
- Push 0x41, 0x42, 0x43 on consecutive clocks, then three pops spaced 4 clocks apart:
  - `data_out` reads 0x41, 0x42, 0x43 in order;
  - `level` steps 3→2→1→0;
  - `fifo_empty`=1 after the third pop.
- Push 16 bytes 0x00..0x0F (DEPTH_LOG2=4):
  - `fifo_full`=1 and `level`=16.
  - A 17th push of 0xAA is dropped; the 16 pops that follow return 0x00..0x0F.
  - With the macro defined, `overflow`=1 until `clr_err` is pulsed.
- With the FIFO full, push 0x55 and pop in the same cycle:
  - `level` stays 16;
  - `data_out` gets the old head;
  - 0x55 emerges last;
  - `overflow` stays 0.
- Wrap-around: 40 push/pop pairs of an incrementing pattern with `level` held at 1..3:
  - data order is preserved across pointer wrap.
- Mid-stream events:
  - `flush` with `level`=5 plus a simultaneous push: `level`=0 and `fifo_empty`=1 next cycle.
  - Pop while empty: `data_out` unchanged.
  - `reset_n` pulsed low mid-stream: all reset values return within the same cycle.
